signed_divider_seq: RTL and testbench
=====================================

Name: signed_divider_seq

Overview:
- Sequential signed restoring divider: 8-bit dividend / 8-bit divisor.
- Inverse operation of the team's signed multiplier datapath; shares the same operand switches and debounced start pulse.
- Outputs quotient and remainder as magnitude plus sign, so results feed bin2bcd and the display numsel path unchanged.
- One quotient bit per clock; truncating division: quotient rounds toward zero, remainder takes the dividend's sign.

Parameters:
- WIDTH, 8, operand width in bits, two's complement; all widths below scale with WIDTH.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- dividend  input  WIDTH  signed dividend, two's complement, MSB at index WIDTH-1
- divisor  input  WIDTH  signed divisor, two's complement
- start  input  1  single-cycle pulse from push_button_detector
- busy  output  1  high while a division is in progress
- done  output  1  level; results valid; held until next accepted start
- quotient  output  WIDTH  quotient magnitude (0..2^(WIDTH-1))
- q_sign  output  1  quotient sign, 1 = negative
- remainder  output  WIDTH-1  remainder magnitude
- r_sign  output  1  remainder sign, 1 = negative
- div_by_zero  output  1  divisor was zero for the latched operation

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy=0, done=0, quotient=0, q_sign=0, remainder=0, r_sign=0, div_by_zero=0; internal registers and iteration counter cleared.
- FSM states: IDLE, CALC, FINISH, DONE.
- IDLE/DONE, start=1 at edge N, divisor != 0:
  - Latch |dividend|, |divisor|, sign_a, sign_b.
  - Clear partial remainder.
  - Set counter=0; go to CALC; busy=1, done=0.
- IDLE/DONE, start=1 at edge N, divisor == 0:
  - Go directly to DONE at edge N+1 with div_by_zero=1, quotient=0, remainder=0, both signs 0.
  - busy stays 0.
- CALC, one restoring step per edge:
  - Shift {partial remainder, quotient register} left by 1, bringing in the next dividend magnitude bit, MSB first.
  - Trial-subtract the divisor magnitude. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0.
  - Partial remainder register is WIDTH+1 bits, so the |dividend|=2^(WIDTH-1) case does not overflow.
  - Counter increments each step. After WIDTH steps (edges N+1..N+WIDTH), go to FINISH.
- FINISH, edge N+WIDTH+1:
  - Register outputs and go to DONE: done=1, busy=0, div_by_zero=0.
  - q_sign = sign_a XOR sign_b, forced to 0 if quotient==0.
  - r_sign = sign_a, forced to 0 if remainder==0.
- Latency: start sampled at edge N -> done=1 visible after edge N+9 for WIDTH=8.
- DONE: outputs held stable; done held high until the next accepted start.
- start in CALC/FINISH: ignored; the operation continues unaffected.
- start accepted in DONE: done drops and busy rises at the next edge; the new operation proceeds.
- Operands are sampled only at the accepting edge; later changes on dividend/divisor have no effect on the running operation.
- Most-negative case (-2^(WIDTH-1) / -1): quotient=2^(WIDTH-1)=128, q_sign=0; no overflow flag, since the magnitude fits.
- Reset asserted mid-operation: immediate return to the reset values above; no partial result is ever exposed.
- Outputs change only on clk edges or on reset.

Test Plan:
- Reset release, no start for 20 cycles -> all outputs 0, state IDLE.
- dividend=100, divisor=7, start pulse -> done after exactly 9 edges; quotient=14, q_sign=0, remainder=2, r_sign=0; busy high for 8 cycles.
- dividend=-100, divisor=7 -> quotient=14, q_sign=1, remainder=2, r_sign=1. dividend=100, divisor=-7 -> quotient=14, q_sign=1, remainder=2, r_sign=0.
- dividend=-128, divisor=-1 -> quotient=128, q_sign=0, remainder=0, r_sign=0. dividend=3, divisor=-7 -> quotient=0, q_sign=0, remainder=3, r_sign=0.
- dividend=5, divisor=0 -> div_by_zero=1, done=1 one edge after start, quotient=0, busy never high. Then 10/3 -> div_by_zero=0, quotient=3, remainder=1.
- Extra start pulse at CALC step 4 of 100/7 -> ignored, result 14 r 2. Reset pulsed at step 5 -> outputs 0 immediately, done stays 0. Back-to-back start in DONE -> done falls next edge, new result valid 9 edges later.

Source files
------------

// File: rtl/signed_divider_seq.sv
// Sequential signed restoring divider, one quotient bit per clock; done rises WIDTH+1 edges after an accepted start.
// Results are sign/magnitude and held until the next accepted start; start is ignored while an operation runs.
module signed_divider_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic             q_sign,
   output logic [WIDTH-2:0] remainder,
   output logic             r_sign,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CALC, FINISH, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   pr;
   logic             sign_a;
   logic             sign_b;
   logic             dbz;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   pr_shift;
   logic [WIDTH+1:0] trial;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
   endfunction

   // q_reg starts as |dividend| and is shifted out MSB first while quotient bits shift in at the LSB.
   assign pr_shift = {pr[WIDTH-1:0], q_reg[WIDTH-1]};
   assign trial    = {1'b0, pr_shift} - {2'b00, b_mag};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         q_reg       <= '0;
         b_mag       <= '0;
         pr          <= '0;
         sign_a      <= 1'b0;
         sign_b      <= 1'b0;
         dbz         <= 1'b0;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         q_sign      <= 1'b0;
         remainder   <= '0;
         r_sign      <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  q_reg  <= magnitude(dividend);
                  b_mag  <= magnitude(divisor);
                  sign_a <= dividend[WIDTH-1];
                  sign_b <= divisor[WIDTH-1];
                  pr     <= '0;
                  cnt    <= '0;
                  done   <= 1'b0;
                  // A zero divisor skips the iterations and reports through FINISH one edge later.
                  if (divisor == '0) begin
                     dbz   <= 1'b1;
                     state <= FINISH;
                  end else begin
                     dbz   <= 1'b0;
                     busy  <= 1'b1;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (!trial[WIDTH+1]) begin
                  pr    <= trial[WIDTH:0];
                  q_reg <= {q_reg[WIDTH-2:0], 1'b1};
               end else begin
                  pr    <= pr_shift;
                  q_reg <= {q_reg[WIDTH-2:0], 1'b0};
               end
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  busy  <= 1'b0;
                  state <= FINISH;
               end
            end
            FINISH: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               div_by_zero <= dbz;
               if (dbz) begin
                  quotient  <= '0;
                  q_sign    <= 1'b0;
                  remainder <= '0;
                  r_sign    <= 1'b0;
               end else begin
                  quotient  <= q_reg;
                  q_sign    <= (sign_a ^ sign_b) && (q_reg != '0);
                  remainder <= pr[WIDTH-2:0];
                  r_sign    <= sign_a && (pr != '0);
               end
               state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Randomised and directed bench for signed_divider_seq with a queue-based scoreboard.
module tb_signed_divider_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] dividend = '0;
   logic [7:0] divisor = '0;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic       q_sign;
   logic [6:0] remainder;
   logic       r_sign;
   logic       div_by_zero;

   signed_divider_seq #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .dividend(dividend), .divisor(divisor), .start(start),
      .busy(busy), .done(done), .quotient(quotient), .q_sign(q_sign),
      .remainder(remainder), .r_sign(r_sign), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      int q;
      bit qs;
      int r;
      bit rs;
      bit dbz;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   prev_done = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Truncating signed division straight from the language's / and % operators.
   function automatic exp_t model(input int a, input int b);
      exp_t e;
      int   qt, rt;
      e = '{0, 1'b0, 0, 1'b0, 1'b0};
      if (b == 0) begin
         e.dbz = 1'b1;
      end else begin
         qt   = a / b;
         rt   = a % b;
         e.q  = (qt < 0) ? -qt : qt;
         e.qs = (qt < 0);
         e.r  = (rt < 0) ? -rt : rt;
         e.rs = (rt < 0);
      end
      return e;
   endfunction

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst && done && !prev_done) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_done: got done with empty scoreboard, expected none at %0t", $time);
            end else begin
               e = sb.pop_front();
               chk("quotient", int'(quotient), e.q);
               chk("q_sign", int'(q_sign), int'(e.qs));
               chk("remainder", int'(remainder), e.r);
               chk("r_sign", int'(r_sign), int'(e.rs));
               chk("div_by_zero", int'(div_by_zero), int'(e.dbz));
            end
         end
         prev_done = done;
      end
   end

   // j counts edges after the accepting edge N; sampling happens on the following falling edge.
   task automatic do_op(input int a, input int b, input int extra_at);
      int lat, busy_cnt;
      @(negedge clk);
      dividend = a[7:0];
      divisor  = b[7:0];
      start    = 1'b1;
      sb.push_back(model(a, b));
      lat      = -1;
      busy_cnt = 0;
      for (int j = 0; j < 30; j++) begin
         @(negedge clk);
         if (j == 0) begin
            start    = 1'b0;
            dividend = 8'($urandom);
            divisor  = 8'($urandom);
         end
         if (j == extra_at) start = 1'b1;
         else if (j == extra_at + 1) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            lat = j;
            break;
         end
      end
      chk("latency", lat, (b == 0) ? 1 : 9);
      chk("busy_cycles", busy_cnt, (b == 0) ? 0 : 8);
      repeat (2) @(negedge clk);
      chk("done_held", int'(done), 1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_quotient"}, int'(quotient), 0);
      chk({tag, "_q_sign"}, int'(q_sign), 0);
      chk({tag, "_remainder"}, int'(remainder), 0);
      chk({tag, "_r_sign"}, int'(r_sign), 0);
      chk({tag, "_div_by_zero"}, int'(div_by_zero), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int a, b;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk_all_zero("reset");

      do_op(100, 7, -1);
      do_op(-100, 7, -1);
      do_op(100, -7, -1);
      do_op(-128, -1, -1);
      do_op(3, -7, -1);
      do_op(5, 0, -1);
      do_op(10, 3, -1);
      do_op(100, 7, 3);

      // Abort a running 100/7 with reset during its fifth step.
      @(negedge clk);
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 chk_all_zero("mid_reset");
      @(negedge clk);
      rst = 1'b1;
      repeat (12) @(negedge clk);
      chk("done_after_abort", int'(done), 0);

      do_op(50, -6, -1);
      do_op(-77, 9, -1);
      do_op(-128, 1, -1);
      do_op(-1, -128, -1);

      repeat (40) begin
         a = int'($urandom_range(0, 255)) - 128;
         if ($urandom_range(0, 9) == 0) b = 0;
         else b = int'($urandom_range(0, 255)) - 128;
         do_op(a, b, -1);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
